uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   UART receiver on uart0_rx (syzygy0[0]) ahead of the SoC's UART0 register interface.
//   - Synchronises the asynchronous pad and decodes 8N1 frames at a fixed baud rate.
//   - Buffers received bytes in a first-word-fall-through FIFO.
//   - Presents the bytes to the SoC as a valid/ready stream.
//   - Reports framing and overrun events as single-cycle pulses.
// PARAMETERS
//   CLK_FREQ   60000000  sys_clk frequency, Hz
//   BAUD       115200    line rate, bit/s
//   DEPTH      16        FIFO entries; power of two, >= 2
// PORTS
//   sys_clk     in   1                  system clock
//   sys_rst     in   1                  synchronous active-high reset
//   uart_rx     in   1                  raw pad input, asynchronous; idles high
//   rx_data     out  8                  head-of-FIFO byte
//   rx_valid    out  1                  FIFO non-empty
//   rx_ready    in   1                  consumer accepts rx_data when rx_valid & rx_ready
//   rx_level    out  $clog2(DEPTH)+1    bytes currently held
//   frame_err   out  1                  1-cycle pulse: stop bit sampled low
//   overrun     out  1                  1-cycle pulse: completed byte dropped, FIFO full
// BEHAVIOUR
//   Clocking: one clock. sys_clk drives every flop. sys_rst is synchronous and active-high.
//   Reset: all outputs are reset as follows.
//     - rx_valid=0, rx_level=0, frame_err=0, overrun=0, rx_data=0.
//     - Synchroniser flops reset to 1 (idle line). FSM goes to IDLE.
//     - A frame in progress is discarded. FIFO contents are discarded.
//   Divider: DIV = (CLK_FREQ + BAUD/2) / BAUD, using integer division. HALF = DIV/2.
//     Bit counter width is $clog2(DIV)+1.
//   Sync: 2-FF synchroniser on uart_rx. The FSM sees only the second stage, rxs.
//   FSM:
//     IDLE : rxs==0 -> START, timer cleared.
//     START: after HALF cycles, sample rxs.
//            - rxs==1: false start, go to IDLE with no flags.
//            - rxs==0: go to DATA, timer cleared, bit index 0.
//     DATA : every DIV cycles, sample rxs into shift[idx], LSB first.
//            After idx 7, go to PAR if parity is enabled, else go to STOP.
//     STOP : after DIV cycles, sample rxs.
//            - 1: push byte.
//            - 0: frame_err=1 for one cycle, byte dropped.
//            Either way return to IDLE in the same cycle. A start bit may begin on the next cycle.
//   FIFO:
//     - FWFT: rx_data is valid whenever rx_valid=1.
//     - Pop on rx_valid & rx_ready.
//     - Push lands in the cycle after the stop-bit sample: rx_valid rises 1 cycle after
//       that sample when the FIFO was empty.
//     - Push while full succeeds only if a pop occurs in the same cycle. Otherwise the byte
//       is dropped, overrun=1 for one cycle, and FIFO contents are unchanged.
//     - Simultaneous push and pop: rx_level is unchanged and the pointers both advance.
//     - Pop while empty is ignored.
//     - Pointers are $clog2(DEPTH) bits and wrap naturally.
//     - rx_level saturates at DEPTH by construction.
//   frame_err and overrun never assert in the same cycle. A framing-error byte is never pushed.
// CONFIGURATION
//   UART_RX_PARITY_EN
//     Defined: adds state PAR between DATA and STOP.
//       - One extra bit sampled after DIV cycles; even parity expected.
//       - Mismatch drops the byte and pulses frame_err in the STOP-sample cycle.
//         The stop bit is still consumed.
//     Undefined: 8N1 only; no PAR state or logic.
// TESTING
//   Bench values: CLK_FREQ=1000000, BAUD=100000, so DIV=10 and HALF=5. DEPTH=4.
//   1. Reset.
//      Stimulus: assert sys_rst 3 cycles, then release; hold uart_rx=1.
//      Response: all outputs 0, rx_level 0 for 100 cycles.
//   2. Single byte.
//      Stimulus: send 0x55 with rx_ready=0.
//      Response: rx_valid rises at 98±2 cycles after the start edge; rx_data=0x55; rx_level=1.
//      Then pulse rx_ready for 1 cycle: rx_valid=0 next cycle.
//   3. Overrun.
//      Stimulus: send 0x01..0x05 back-to-back with rx_ready=0.
//      Response: rx_level=4; overrun pulses once on the 5th byte.
//      Draining yields 0x01,0x02,0x03,0x04.
//   4. Framing error.
//      Stimulus: send 0xA3 with the stop bit held low.
//      Response: frame_err pulses once; rx_level stays 0.
//      A following 0x3C is received correctly.
//   5. False start and mid-frame reset.
//      Stimulus: 3-cycle low glitch on uart_rx.
//      Response: no push, no flags.
//      Stimulus: assert sys_rst during DATA of 0x7E.
//      Response: no push; the next frame 0x81 is received.
//   6. Full with simultaneous pop (PARITY_EN off).
//      Stimulus: FIFO full, rx_ready=1 in the push cycle.
//      Response: no overrun; rx_level stays 4; the new byte is last out.
//      PARITY_EN on: a bad-parity byte gives a frame_err pulse and is not pushed.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a 2-FF pad synchroniser and a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_fifo #(
  parameter int CLK_FREQ = 60000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     uart_rx,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [$clog2(DEPTH):0]   rx_level,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int DIV  = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV) + 1;
  localparam int AW   = $clog2(DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state;
  logic            sync_p0;
  logic            rxs;
  logic [CW-1:0]   timer;
  logic [2:0]      idx;
  logic [7:0]      shift;
  logic            tick;
  logic            push_req;
`ifdef UART_RX_PARITY_EN
  logic            parity_bad;
`endif

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            pop;
  logic            full;
  logic            do_push;

  // Stage p0/p1: pad synchroniser, idles high
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_p0 <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      sync_p0 <= uart_rx;
      rxs     <= sync_p0;
    end
  end

  // START waits half a bit to land mid start bit; every later state waits a full bit
  always_comb begin
    tick = (state == START) ? (timer == CW'(HALF - 1)) : (timer == CW'(DIV - 1));
  end

  // Frame decoder
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      timer     <= '0;
      idx       <= '0;
      push_req  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad <= 1'b0;
`endif
    end else begin
      push_req  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          if (tick) begin
            timer <= '0;
            idx   <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            timer <= timer + CW'(1);
          end
        end
        DATA: begin
          if (tick) begin
            timer <= '0;
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PAR;
`else
              state <= STOP;
`endif
            end
          end else begin
            timer <= timer + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PAR: begin
          if (tick) begin
            timer      <= '0;
            parity_bad <= (^shift) ^ rxs;
            state      <= STOP;
          end else begin
            timer <= timer + CW'(1);
          end
        end
`endif
        STOP: begin
          if (tick) begin
            timer <= '0;
            state <= IDLE;
`ifdef UART_RX_PARITY_EN
            if (rxs && !parity_bad) push_req <= 1'b1;
            else                    frame_err <= 1'b1;
`else
            if (rxs) push_req  <= 1'b1;
            else     frame_err <= 1'b1;
`endif
          end else begin
            timer <= timer + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift register holds the byte until the push lands; the next frame cannot overwrite it sooner
  always_ff @(posedge sys_clk) begin
    if (state == DATA && tick) shift[idx] <= rxs;
  end

  always_comb begin
    pop     = rx_valid & rx_ready;
    full    = (count == (AW + 1)'(DEPTH));
    do_push = push_req & (!full | pop);
  end

  // FIFO stage: push lands one cycle after the stop-bit sample
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push_req & full & !pop;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= shift;
  end

  assign rx_valid = (count != '0);
  assign rx_level = count;
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed frames plus randomized traffic, scored against a
// queue model that predicts when each frame's push, overrun or framing pulse must appear.
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int DEPTH    = 4;
  localparam int DIV      = 10;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS    = 11;
`else
  localparam int NBITS    = 10;
`endif
  // Drive of the start bit lands between edge p and p+1; two sync flops, half a bit,
  // the data/parity bits and the stop bit put the stop sample on edge p+NBITS*DIV-2.
  localparam int LAT_FE   = NBITS * DIV - 2;
  localparam int LAT_PUSH = NBITS * DIV - 1;

  logic       sys_clk;
  logic       sys_rst;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [2:0] rx_level;
  logic       frame_err;
  logic       overrun;

  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rx(uart_rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_level(rx_level), .frame_err(frame_err), .overrun(overrun)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         t;
    bit         fe;
    logic [7:0] b;
  } ev_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         armed = 0;
  int         fe_pulses = 0;
  int         ov_pulses = 0;
  int         rise_cyc = -1;
  bit         prev_valid = 0;
  int         last_p = 0;
  logic [7:0] mq[$];
  ev_t        evq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model advance and per-cycle comparison
  initial begin
    forever begin
      @(posedge sys_clk);
      cyc++;
      #1;
      begin
        bit exp_fe;
        bit exp_ov;
        bit do_pop;
        exp_fe = 0;
        exp_ov = 0;
        if (sys_rst) begin
          mq.delete();
          evq.delete();
          armed = 1;
        end else if (armed) begin
          do_pop = rx_ready && (mq.size() > 0);
          if (do_pop) void'(mq.pop_front());
          while (evq.size() > 0 && evq[0].t <= cyc) begin
            if (evq[0].fe) exp_fe = 1;
            else if (mq.size() >= DEPTH) exp_ov = 1;
            else mq.push_back(evq[0].b);
            void'(evq.pop_front());
          end
        end
        if (armed) begin
          chk("valid", rx_valid, (mq.size() > 0) ? 1 : 0);
          chk("level", rx_level, mq.size());
          chk("frame_err", frame_err, exp_fe);
          chk("overrun", overrun, exp_ov);
          if (mq.size() > 0) chk("data", rx_data, mq[0]);
        end
        if (frame_err) fe_pulses++;
        if (overrun) ov_pulses++;
        if (rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = rx_valid;
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit bad_stop, input bit bad_par,
                      input bit rnd_ready, input int ready_off, input int rst_bit);
    logic [NBITS-1:0] bits;
    ev_t e;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
    bits[9] = (^b) ^ bad_par;
`endif
    bits[NBITS-1] = ~bad_stop;
    for (int k = 0; k < NBITS * DIV; k++) begin
      @(negedge sys_clk);
      if (k == 0) begin
        last_p = cyc;
        if (rst_bit < 0) begin
          e.fe = bad_stop | bad_par;
          e.t  = cyc + (e.fe ? LAT_FE : LAT_PUSH);
          e.b  = b;
          evq.push_back(e);
        end
      end
      uart_rx = bits[k / DIV];
      if (rst_bit >= 0) sys_rst = ((k / DIV) >= rst_bit);
      if (rnd_ready) rx_ready = ($urandom_range(0, 2) == 0);
      else if (ready_off >= 0) rx_ready = (k == ready_off);
    end
  endtask

  task automatic idle(input int n, input bit rnd_ready);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      uart_rx = 1'b1;
      sys_rst = 1'b0;
      if (rnd_ready) rx_ready = ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic pop_expect(input string name, input int exp);
    @(negedge sys_clk);
    chk({name, "_valid"}, rx_valid, 1);
    chk(name, rx_data, exp);
    rx_ready = 1'b1;
    @(negedge sys_clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!rx_valid && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    chk("wait_valid_timeout", rx_valid, 1);
  endtask

  initial begin
    int fe0;
    int ov0;
    int lat;
    uart_rx  = 1'b1;
    sys_rst  = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_level", rx_level, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    sys_rst = 1'b0;
    idle(100, 0);
    chk("idle_level", rx_level, 0);
    chk("idle_flags", fe_pulses + ov_pulses, 0);

    // Single byte and its latency
    send(8'h55, 0, 0, 0, -1, -1);
    wait_valid(20);
    lat = rise_cyc - last_p;
    chk("latency_in_window", (lat >= LAT_PUSH - 3 && lat <= LAT_PUSH + 1) ? 1 : 0, 1);
    chk("single_data", rx_data, 8'h55);
    chk("single_level", rx_level, 1);
    @(negedge sys_clk);
    rx_ready = 1'b1;
    @(negedge sys_clk);
    rx_ready = 1'b0;
    chk("single_popped", rx_valid, 0);

    // Overrun on the fifth back-to-back byte
    ov0 = ov_pulses;
    for (int i = 1; i <= 5; i++) send(8'(i), 0, 0, 0, -1, -1);
    idle(5, 0);
    chk("ovr_level", rx_level, 4);
    chk("ovr_pulses", ov_pulses - ov0, 1);
    for (int i = 1; i <= 4; i++) pop_expect("ovr_drain", i);
    chk("ovr_empty", rx_level, 0);

    // Framing error then a clean byte
    fe0 = fe_pulses;
    send(8'hA3, 1, 0, 0, -1, -1);
    idle(25, 0);
    chk("fe_pulses", fe_pulses - fe0, 1);
    chk("fe_level", rx_level, 0);
    send(8'h3C, 0, 0, 0, -1, -1);
    idle(5, 0);
    chk("after_fe_level", rx_level, 1);
    pop_expect("after_fe_data", 8'h3C);

    // False start glitch, then reset in the middle of a frame
    fe0 = fe_pulses;
    ov0 = ov_pulses;
    @(negedge sys_clk);
    uart_rx = 1'b0;
    repeat (3) @(negedge sys_clk);
    uart_rx = 1'b1;
    idle(25, 0);
    chk("glitch_level", rx_level, 0);
    chk("glitch_flags", (fe_pulses - fe0) + (ov_pulses - ov0), 0);
    send(8'h7E, 0, 0, 0, -1, 3);
    idle(20, 0);
    chk("midrst_level", rx_level, 0);
    send(8'h81, 0, 0, 0, -1, -1);
    idle(5, 0);
    chk("midrst_next_level", rx_level, 1);
    pop_expect("midrst_next_data", 8'h81);

    // Push into a full FIFO while a pop happens in the same cycle
    ov0 = ov_pulses;
    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 0, 0, 0, -1, -1);
    send(8'h99, 0, 0, 0, LAT_PUSH - 1, -1);
    rx_ready = 1'b0;
    idle(5, 0);
    chk("fullpop_overrun", ov_pulses - ov0, 0);
    chk("fullpop_level", rx_level, 4);
    pop_expect("fullpop_d0", 8'h12);
    pop_expect("fullpop_d1", 8'h13);
    pop_expect("fullpop_d2", 8'h14);
    pop_expect("fullpop_d3", 8'h99);

`ifdef UART_RX_PARITY_EN
    fe0 = fe_pulses;
    send(8'h5A, 0, 1, 0, -1, -1);
    idle(25, 0);
    chk("parity_fe", fe_pulses - fe0, 1);
    chk("parity_level", rx_level, 0);
`endif

    // Randomized traffic with random consumer back-pressure
    for (int n = 0; n < 150; n++) begin
      bit bad;
      bad = ($urandom_range(0, 9) == 0);
      send(8'($urandom), bad, 0, 1, -1, -1);
      idle(bad ? 20 : $urandom_range(0, 3), 1);
    end
    rx_ready = 1'b1;
    idle(10, 0);
    rx_ready = 1'b0;
    idle(2, 0);
    chk("final_empty", rx_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
